riscv_top: RTL and testbench
============================

RISCV_TOP -- requirements
Module: riscv_top

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: byte address fetched first after reset.
REQ-002 SHALL have parameter MEM_ADDR_BITS, default 14: word-address width of unified memory (16384 x 32-bit words).
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port wb_data, output, 32 bits: value selected for register write-back in the current cycle.

Function
REQ-006 SHALL be a single-cycle RV32I core: fetch, decode, register read, execute, memory access and write-back complete within one clock; one instruction retires per cycle.
REQ-007 SHALL contain one unified memory array named ram, word-indexed by byte_address[MEM_ADDR_BITS+1:2], preloadable by simulation file load, never cleared by reset.
REQ-008 SHALL provide an instruction read port and a data read port on ram, both combinational; address bits [1:0] ignored.
REQ-009 SHALL write ram on the rising clock edge for SW only, full 32-bit word.
REQ-010 SHALL contain a 32 x 32-bit register file named reg_file: two combinational read ports, one write port written on the rising edge.
REQ-011 SHALL read x0 as 0 and ignore writes to x0.
REQ-012 SHALL return the newly written value on a read of a register only in the cycle after the write.
REQ-013 SHALL execute LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, LW, SW, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
REQ-014 SHALL use 32-bit wrap-around arithmetic; SLT/BLT/BGE signed, SLTU/BLTU/BGEU unsigned; shift amount = low 5 bits; SRA/SRAI sign-fill.
REQ-015 SHALL sign-extend I/S/B/J immediates and place the U immediate in bits [31:12].
REQ-016 SHALL set next PC = PC+4 by default, PC+B-imm on a taken branch, PC+J-imm for JAL, (rs1+imm) with bit 0 cleared for JALR.
REQ-017 SHALL write PC+4 to rd for JAL/JALR.
REQ-018 SHALL drive wb_data as follows:
- loaded word for LW
- PC+4 for JAL/JALR
- ALU result for all other instructions, including non-writing ones.
REQ-019 SHALL treat any unsupported opcode (FENCE, ECALL, EBREAK, CSR, byte/halfword loads and stores included) as a NOP: PC+4, no register or memory write.
REQ-020 SHALL assert no alignment exception; misaligned targets are fetched with bits [1:0] ignored.

Reset
REQ-021 SHALL, while reset is low, asynchronously force PC to RESET_PC and suppress register-file and memory writes.
REQ-022 SHALL drive wb_data to 0 while reset is low.
REQ-023 SHALL clear all reg_file entries to 0 while reset is low.
REQ-024 SHALL fetch from RESET_PC on the first rising edge after reset deasserts.
REQ-025 SHALL, when reset is asserted mid-program, abandon the in-flight instruction with no partial writes.

Verification
REQ-026 SHALL pass: ram[0]=ADDI x1,x0,5; ram[1]=ADD x2,x1,x1; release reset -> x1=5 after edge 1, x2=10 after edge 2, wb_data=10 during cycle 2.
REQ-027 SHALL pass: ADDI x0,x0,7 executed -> x0 remains 0, wb_data=7.
REQ-028 SHALL pass: SW x1,16(x0) with x1=0xDEADBEEF, then LW x3,16(x0) -> ram[4]=0xDEADBEEF, x3=0xDEADBEEF.
REQ-029 SHALL pass: BEQ taken with offset +8 at PC 0x10 -> next PC 0x18; JAL x1,+12 at PC 0x20 -> PC 0x2C, x1=0x24.
REQ-030 SHALL pass: SLT/SLTU with x1=0xFFFFFFFF, x2=1 -> SLT=1, SLTU=0; SRAI x1,4 -> 0xFFFFFFFF.
REQ-031 SHALL pass: Euclid GCD program loaded, run 1600 cycles -> x9=0x00000010; Fibonacci program -> x9=0x00000015; assert reset mid-run -> PC=RESET_PC immediately, all registers 0.

Source files
------------

// File: rtl/riscv_top.sv
// rtl/riscv_top.sv - single-cycle RV32I core with unified word memory
// Unsupported encodings retire as NOPs; reset clears the register file but never the memory.
module riscv_top #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          MEM_ADDR_BITS = 14
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] wb_data
);
   localparam int MEM_WORDS = 1 << MEM_ADDR_BITS;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   logic [31:0] ram      [0:MEM_WORDS-1];
   logic [31:0] reg_file [0:31];

   logic [31:0] pc_q, pc_d, pc_plus4;
   logic [31:0] instr;
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_val, rs2_val, op_b;
   logic [31:0] alu_out, result, load_data;
   logic [4:0]  shamt;
   logic        f7_zero, f7_alt, alu_legal, taken;
   logic        rf_we, mem_we, is_load, is_jump;

   assign instr    = ram[pc_q[MEM_ADDR_BITS+1:2]];
   assign pc_plus4 = pc_q + 32'd4;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   assign rs1_val = (rs1 == 5'd0) ? 32'd0 : reg_file[rs1];
   assign rs2_val = (rs2 == 5'd0) ? 32'd0 : reg_file[rs2];

   assign op_b    = (opcode == OP_REG) ? rs2_val : imm_i;
   assign shamt   = op_b[4:0];
   assign f7_zero = (funct7 == 7'b0000000);
   assign f7_alt  = (funct7 == 7'b0100000);

   // Register form allows the alternate funct7 only for SUB/SRA; immediate form only constrains shifts.
   always_comb begin
      alu_legal = 1'b1;
      if (opcode == OP_REG)
         alu_legal = f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101));
      else if (funct3 == 3'b001)
         alu_legal = f7_zero;
      else if (funct3 == 3'b101)
         alu_legal = f7_zero || f7_alt;
   end

   always_comb begin
      alu_out = 32'd0;
      case (funct3)
         3'b000:  alu_out = (opcode == OP_REG && f7_alt) ? rs1_val - op_b : rs1_val + op_b;
         3'b001:  alu_out = rs1_val << shamt;
         3'b010:  alu_out = {31'd0, $signed(rs1_val) < $signed(op_b)};
         3'b011:  alu_out = {31'd0, rs1_val < op_b};
         3'b100:  alu_out = rs1_val ^ op_b;
         3'b101:  alu_out = f7_alt ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
         3'b110:  alu_out = rs1_val | op_b;
         default: alu_out = rs1_val & op_b;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = (rs1_val == rs2_val);
         3'b001:  taken = (rs1_val != rs2_val);
         3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
         3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110:  taken = (rs1_val <  rs2_val);
         3'b111:  taken = (rs1_val >= rs2_val);
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      result  = 32'd0;
      pc_d    = pc_plus4;
      rf_we   = 1'b0;
      mem_we  = 1'b0;
      is_load = 1'b0;
      is_jump = 1'b0;
      case (opcode)
         OP_LUI: begin
            result = imm_u;
            rf_we  = 1'b1;
         end
         OP_AUIPC: begin
            result = pc_q + imm_u;
            rf_we  = 1'b1;
         end
         OP_JAL: begin
            result  = pc_q + imm_j;
            pc_d    = result;
            rf_we   = 1'b1;
            is_jump = 1'b1;
         end
         OP_JALR: begin
            if (funct3 == 3'b000) begin
               result  = rs1_val + imm_i;
               pc_d    = {result[31:1], 1'b0};
               rf_we   = 1'b1;
               is_jump = 1'b1;
            end
         end
         OP_BRANCH: begin
            result = rs1_val - rs2_val;
            if (taken)
               pc_d = pc_q + imm_b;
         end
         OP_LOAD: begin
            if (funct3 == 3'b010) begin
               result  = rs1_val + imm_i;
               rf_we   = 1'b1;
               is_load = 1'b1;
            end
         end
         OP_STORE: begin
            if (funct3 == 3'b010) begin
               result = rs1_val + imm_s;
               mem_we = 1'b1;
            end
         end
         OP_IMM, OP_REG: begin
            if (alu_legal) begin
               result = alu_out;
               rf_we  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign load_data = ram[result[MEM_ADDR_BITS+1:2]];

   always_comb begin
      if (!reset)
         wb_data = 32'd0;
      else if (is_load)
         wb_data = load_data;
      else if (is_jump)
         wb_data = pc_plus4;
      else
         wb_data = result;
   end

   // ram is deliberately absent from the reset branch so preloaded contents survive reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q <= RESET_PC;
         for (int i = 0; i < 32; i++)
            reg_file[i] <= 32'd0;
      end else begin
         pc_q <= pc_d;
         if (rf_we && rd != 5'd0)
            reg_file[rd] <= wb_data;
         if (mem_we)
            ram[result[MEM_ADDR_BITS+1:2]] <= rs2_val;
      end
   end
endmodule

// File: tb/tb_riscv_top.sv
// tb/tb_riscv_top.sv - directed self-checking bench for riscv_top
module tb_riscv_top;
   logic        clock;
   logic        reset;
   logic [31:0] wb_data;

   int total = 0;
   int bad   = 0;

   localparam logic [6:0] OPI  = 7'b0010011;
   localparam logic [6:0] LD   = 7'b0000011;
   localparam logic [6:0] JALR = 7'b1100111;

   riscv_top dut (
      .clock   (clock),
      .reset   (reset),
      .wb_data (wb_data)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] b_type(input logic [12:0] off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
      return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] j_type(input logic [20:0] off, input logic [4:0] rd);
      return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
   endfunction

   task automatic prep();
      reset = 1'b0;
      @(negedge clock);
      for (int i = 0; i < 16384; i++)
         dut.ram[i] = 32'd0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      logic ok;
      prep();
      dut.ram[0] = i_type(12'd5, 5'd0, 3'b000, 5'd1, OPI);
      #1;
      total++;
      if (wb_data !== 32'd0) begin
         bad++;
         $display("FAIL reset_wb actual=%h expected=%h", wb_data, 32'd0);
      end
      total++;
      if (dut.pc_q !== 32'd0) begin
         bad++;
         $display("FAIL reset_pc actual=%h expected=%h", dut.pc_q, 32'd0);
      end
      ok = 1'b1;
      for (int r = 0; r < 32; r++)
         if (dut.reg_file[r] !== 32'd0) ok = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL reset_regs actual=nonzero expected=all_zero");
      end
   endtask

   task automatic test_add_chain();
      prep();
      dut.ram[0] = i_type(12'd5, 5'd0, 3'b000, 5'd1, OPI);
      dut.ram[1] = r_type(7'd0, 5'd1, 5'd1, 3'b000, 5'd2);
      reset = 1'b1;
      #1;
      check32("addi_wb_cycle1", wb_data, 32'd5);
      step(1);
      check32("x1_after_edge1", dut.reg_file[1], 32'd5);
      check32("add_wb_cycle2", wb_data, 32'd10);
      step(1);
      check32("x2_after_edge2", dut.reg_file[2], 32'd10);
   endtask

   task automatic test_x0();
      prep();
      dut.ram[0] = i_type(12'd7, 5'd0, 3'b000, 5'd0, OPI);
      reset = 1'b1;
      #1;
      check32("x0_wb", wb_data, 32'd7);
      step(1);
      check32("x0_stays_zero", dut.reg_file[0], 32'd0);
   endtask

   task automatic test_load_store();
      prep();
      dut.ram[0] = {20'hDEADC, 5'd1, 7'b0110111};
      dut.ram[1] = i_type(12'hEEF, 5'd1, 3'b000, 5'd1, OPI);
      dut.ram[2] = s_type(12'd16, 5'd1, 5'd0, 3'b010);
      dut.ram[3] = i_type(12'd16, 5'd0, 3'b010, 5'd3, LD);
      reset = 1'b1;
      step(2);
      check32("lui_addi_x1", dut.reg_file[1], 32'hDEADBEEF);
      step(1);
      check32("sw_ram4", dut.ram[4], 32'hDEADBEEF);
      check32("lw_wb", wb_data, 32'hDEADBEEF);
      step(1);
      check32("lw_x3", dut.reg_file[3], 32'hDEADBEEF);
   endtask

   task automatic test_beq_jal();
      prep();
      dut.ram[4] = b_type(13'd8, 5'd0, 5'd0, 3'b000);
      dut.ram[8] = j_type(21'd12, 5'd1);
      reset = 1'b1;
      step(4);
      check32("pc_at_beq", dut.pc_q, 32'h10);
      step(1);
      check32("beq_target", dut.pc_q, 32'h18);
      step(2);
      check32("jal_wb", wb_data, 32'h24);
      step(1);
      check32("jal_target", dut.pc_q, 32'h2C);
      check32("jal_link", dut.reg_file[1], 32'h24);
   endtask

   task automatic test_branches();
      prep();
      dut.ram[0] = i_type(12'hFFF, 5'd0, 3'b000, 5'd1, OPI);
      dut.ram[1] = i_type(12'd1, 5'd0, 3'b000, 5'd2, OPI);
      dut.ram[2] = b_type(13'd8, 5'd2, 5'd1, 3'b110);
      dut.ram[3] = b_type(13'd8, 5'd2, 5'd1, 3'b100);
      dut.ram[4] = i_type(12'd99, 5'd0, 3'b000, 5'd9, OPI);
      dut.ram[5] = i_type(12'h021, 5'd2, 3'b000, 5'd5, JALR);
      reset = 1'b1;
      step(3);
      check32("bltu_not_taken", dut.pc_q, 32'h0C);
      step(1);
      check32("blt_taken", dut.pc_q, 32'h14);
      step(1);
      check32("jalr_clear_bit0", dut.pc_q, 32'h22);
      check32("jalr_link", dut.reg_file[5], 32'h18);
      check32("skipped_x9", dut.reg_file[9], 32'd0);
   endtask

   task automatic test_alu();
      prep();
      dut.ram[0] = i_type(12'hFFF, 5'd0, 3'b000, 5'd1, OPI);
      dut.ram[1] = i_type(12'd1, 5'd0, 3'b000, 5'd2, OPI);
      dut.ram[2] = r_type(7'd0, 5'd2, 5'd1, 3'b010, 5'd3);
      dut.ram[3] = r_type(7'd0, 5'd2, 5'd1, 3'b011, 5'd4);
      dut.ram[4] = i_type({7'b0100000, 5'd4}, 5'd1, 3'b101, 5'd5, OPI);
      dut.ram[5] = i_type({7'b0000000, 5'd4}, 5'd1, 3'b101, 5'd6, OPI);
      dut.ram[6] = r_type(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd7);
      dut.ram[7] = r_type(7'd0, 5'd1, 5'd2, 3'b001, 5'd8);
      reset = 1'b1;
      step(8);
      check32("slt", dut.reg_file[3], 32'd1);
      check32("sltu", dut.reg_file[4], 32'd0);
      check32("srai", dut.reg_file[5], 32'hFFFFFFFF);
      check32("srli", dut.reg_file[6], 32'h0FFFFFFF);
      check32("sub", dut.reg_file[7], 32'd2);
      check32("sll_shamt31", dut.reg_file[8], 32'h80000000);
   endtask

   task automatic test_nop();
      prep();
      dut.ram[0] = i_type(12'd3, 5'd0, 3'b000, 5'd1, OPI);
      dut.ram[1] = i_type(12'd0, 5'd0, 3'b000, 5'd1, LD);
      dut.ram[2] = s_type(12'd32, 5'd1, 5'd0, 3'b000);
      dut.ram[3] = 32'h0000_0073;
      dut.ram[8] = 32'h1234_5678;
      reset = 1'b1;
      step(4);
      check32("lb_no_write", dut.reg_file[1], 32'd3);
      check32("sb_no_store", dut.ram[8], 32'h1234_5678);
      check32("nop_pc", dut.pc_q, 32'h10);
   endtask

   task automatic test_gcd();
      prep();
      dut.ram[0] = i_type(12'd400, 5'd0, 3'b000, 5'd1, OPI);
      dut.ram[1] = i_type(12'd176, 5'd0, 3'b000, 5'd2, OPI);
      dut.ram[2] = b_type(13'd24, 5'd2, 5'd1, 3'b000);
      dut.ram[3] = b_type(13'd12, 5'd2, 5'd1, 3'b100);
      dut.ram[4] = r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd1);
      dut.ram[5] = j_type(21'h1FFFF4, 5'd0);
      dut.ram[6] = r_type(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd2);
      dut.ram[7] = j_type(21'h1FFFEC, 5'd0);
      dut.ram[8] = i_type(12'd0, 5'd1, 3'b000, 5'd9, OPI);
      dut.ram[9] = j_type(21'd0, 5'd0);
      reset = 1'b1;
      step(1600);
      check32("gcd_x9", dut.reg_file[9], 32'h10);
   endtask

   task automatic test_fib_mid_reset();
      logic ok;
      prep();
      dut.ram[0] = i_type(12'd0, 5'd0, 3'b000, 5'd1, OPI);
      dut.ram[1] = i_type(12'd1, 5'd0, 3'b000, 5'd2, OPI);
      dut.ram[2] = i_type(12'd8, 5'd0, 3'b000, 5'd3, OPI);
      dut.ram[3] = r_type(7'd0, 5'd2, 5'd1, 3'b000, 5'd4);
      dut.ram[4] = i_type(12'd0, 5'd2, 3'b000, 5'd1, OPI);
      dut.ram[5] = i_type(12'd0, 5'd4, 3'b000, 5'd2, OPI);
      dut.ram[6] = i_type(12'hFFF, 5'd3, 3'b000, 5'd3, OPI);
      dut.ram[7] = b_type(13'h1FF0, 5'd0, 5'd3, 3'b001);
      dut.ram[8] = i_type(12'd0, 5'd1, 3'b000, 5'd9, OPI);
      dut.ram[9] = j_type(21'd0, 5'd0);
      reset = 1'b1;
      step(200);
      check32("fib_x9", dut.reg_file[9], 32'h15);
      #2;
      reset = 1'b0;
      #1;
      check32("mid_reset_pc", dut.pc_q, 32'd0);
      check32("mid_reset_wb", wb_data, 32'd0);
      ok = 1'b1;
      for (int r = 0; r < 32; r++)
         if (dut.reg_file[r] !== 32'd0) ok = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL mid_reset_regs actual=nonzero expected=all_zero");
      end
   endtask

   task automatic test_reset_abandons_store();
      prep();
      dut.ram[0]  = i_type(12'd5, 5'd0, 3'b000, 5'd1, OPI);
      dut.ram[1]  = s_type(12'd64, 5'd1, 5'd0, 3'b010);
      dut.ram[16] = 32'hCAFE_F00D;
      reset = 1'b1;
      step(1);
      check32("pre_reset_pc", dut.pc_q, 32'h4);
      reset = 1'b0;
      step(1);
      check32("abandoned_sw", dut.ram[16], 32'hCAFE_F00D);
      check32("abandoned_pc", dut.pc_q, 32'd0);
      check32("abandoned_x1", dut.reg_file[1], 32'd0);
   endtask

   initial begin
      reset = 1'b0;
      test_reset();
      test_add_chain();
      test_x0();
      test_load_store();
      test_beq_jal();
      test_branches();
      test_alu();
      test_nop();
      test_gcd();
      test_fib_mid_reset();
      test_reset_abandons_store();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
